// File: rtl/exposure_sequencer_pkg.sv
// Shared state encoding and default timing constants for the exposure sequencer.
package exposure_sequencer_pkg;

    localparam int DEFAULT_TICKS_PER_MS = 100000;
    localparam int DEFAULT_SETTLE_MS    = 300;
    localparam int DEFAULT_EXP_W        = 24;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_OPEN_SETTLE  = 3'd1,
        ST_EXPOSE       = 3'd2,
        ST_CLOSE_SETTLE = 3'd3,
        ST_READ_REQ     = 3'd4,
        ST_READ_ACK     = 3'd5,
        ST_READ_WAIT    = 3'd6,
        ST_FINISH       = 3'd7
    } state_e;

    // Abort is honoured only before the readout has been requested.
    function automatic logic is_abortable(input state_e s);
        return (s == ST_OPEN_SETTLE) || (s == ST_EXPOSE);
    endfunction

endpackage

// File: rtl/exposure_sequencer_ms_timer.sv
// Millisecond timer: prescaler of TICKS_PER_MS cycles feeding a down-counter of ms.
module ms_timer
    import exposure_sequencer_pkg::*;
#(
    parameter int TICKS_PER_MS = DEFAULT_TICKS_PER_MS,
    parameter int EXP_W        = DEFAULT_EXP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [EXP_W-1:0] ms,
    output logic             expired
);

    localparam int PRE_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MS - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [EXP_W-1:0] ms_q, ms_d;

    always_comb begin
        pre_d = pre_q;
        ms_d  = ms_q;
        if (load) begin
            pre_d = '0;
            ms_d  = ms;
        end else if (ms_q != '0) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                ms_d  = ms_q - EXP_W'(1);
            end else begin
                pre_d = pre_q + PRE_W'(1);
            end
        end
    end

    // Fires on the last cycle of the loaded interval; a zero load fires immediately.
    assign expired = (ms_q == '0) || ((ms_q == EXP_W'(1)) && (pre_q == PRE_LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
            ms_q  <= '0;
        end else begin
            pre_q <= pre_d;
            ms_q  <= ms_d;
        end
    end

endmodule

// File: rtl/exposure_sequencer.sv
// Timed shutter-open / expose / shutter-close / CCD readout sequence for one exposure.
module exposure_sequencer
    import exposure_sequencer_pkg::*;
#(
    parameter int TICKS_PER_MS = DEFAULT_TICKS_PER_MS,
    parameter int SETTLE_MS    = DEFAULT_SETTLE_MS,
    parameter int EXP_W        = DEFAULT_EXP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [EXP_W-1:0] exp_ms,
    input  logic             dark,
    input  logic             readout_busy,
    output logic             shutter_open,
    output logic             readout_toggle,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [2:0]       state_dbg
);

    localparam logic [EXP_W-1:0] SETTLE_CNT = EXP_W'(SETTLE_MS);

    state_e           state_q, state_d;
    logic [EXP_W-1:0] exp_ms_q, exp_ms_d;
    logic             dark_q, dark_d;
    logic             aborted_q, aborted_d;
    logic             shutter_open_q, shutter_open_d;
    logic             readout_toggle_q, readout_toggle_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             timer_load;
    logic [EXP_W-1:0] timer_ms;
    logic             timer_expired;

    ms_timer #(
        .TICKS_PER_MS (TICKS_PER_MS),
        .EXP_W        (EXP_W)
    ) u_ms_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (timer_load),
        .ms      (timer_ms),
        .expired (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        exp_ms_d  = exp_ms_q;
        dark_d    = dark_q;
        aborted_d = aborted_q;

        if (is_abortable(state_q) && abort) begin
            aborted_d = 1'b1;
            state_d   = dark_q ? ST_FINISH : ST_CLOSE_SETTLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        exp_ms_d  = exp_ms;
                        dark_d    = dark;
                        aborted_d = 1'b0;
                        state_d   = dark ? ST_EXPOSE : ST_OPEN_SETTLE;
                    end
                end
                ST_OPEN_SETTLE: begin
                    if (timer_expired) state_d = ST_EXPOSE;
                end
                ST_EXPOSE: begin
                    if (timer_expired) state_d = dark_q ? ST_READ_REQ : ST_CLOSE_SETTLE;
                end
                ST_CLOSE_SETTLE: begin
                    if (abort) aborted_d = 1'b1;
                    if (timer_expired) begin
                        state_d = (aborted_q || abort) ? ST_FINISH : ST_READ_REQ;
                    end
                end
                ST_READ_REQ:  state_d = ST_READ_ACK;
                ST_READ_ACK: begin
                    if (readout_busy) state_d = ST_READ_WAIT;
                end
                ST_READ_WAIT: begin
                    if (!readout_busy) state_d = ST_FINISH;
                end
                ST_FINISH:    state_d = ST_IDLE;
                default:      state_d = ST_IDLE;
            endcase
        end

        // The timer restarts on every state change so each phase is timed from its first cycle.
        timer_load = (state_d != state_q);
        timer_ms   = (state_d == ST_EXPOSE) ? exp_ms_d : SETTLE_CNT;

        shutter_open_d   = !dark_d && ((state_d == ST_OPEN_SETTLE) || (state_d == ST_EXPOSE));
        readout_toggle_d = (state_d == ST_READ_REQ);
        busy_d           = (state_d != ST_IDLE);
        done_d           = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            exp_ms_q         <= '0;
            dark_q           <= 1'b0;
            aborted_q        <= 1'b0;
            shutter_open_q   <= 1'b0;
            readout_toggle_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            exp_ms_q         <= exp_ms_d;
            dark_q           <= dark_d;
            aborted_q        <= aborted_d;
            shutter_open_q   <= shutter_open_d;
            readout_toggle_q <= readout_toggle_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign shutter_open   = shutter_open_q;
    assign readout_toggle = readout_toggle_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign aborted        = aborted_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_exposure_sequencer.sv
// Randomised bench for exposure_sequencer against a timeline model of one exposure sequence.
module tb_exposure_sequencer;

    localparam int TPM = 10;
    localparam int SMS = 2;
    localparam int EW  = 24;
    localparam int S   = SMS * TPM;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [EW-1:0] exp_ms;
    logic          dark;
    logic          readout_busy;
    logic          shutter_open;
    logic          readout_toggle;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [2:0]    state_dbg;

    int checks   = 0;
    int failures = 0;

    exposure_sequencer #(
        .TICKS_PER_MS (TPM),
        .SETTLE_MS    (SMS),
        .EXP_W        (EW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .exp_ms         (exp_ms),
        .dark           (dark),
        .readout_busy   (readout_busy),
        .shutter_open   (shutter_open),
        .readout_toggle (readout_toggle),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .state_dbg      (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Synchronous reset for one cycle, then confirm every output sits at its reset value.
    task automatic resetDut(input int seq);
        @(negedge clk);
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        readout_busy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checkOutput($sformatf("s%0d_rst_shutter", seq), 32'(shutter_open), 32'd0);
        checkOutput($sformatf("s%0d_rst_toggle", seq), 32'(readout_toggle), 32'd0);
        checkOutput($sformatf("s%0d_rst_busy", seq), 32'(busy), 32'd0);
        checkOutput($sformatf("s%0d_rst_done", seq), 32'(done), 32'd0);
        checkOutput($sformatf("s%0d_rst_aborted", seq), 32'(aborted), 32'd0);
        checkOutput($sformatf("s%0d_rst_state", seq), 32'(state_dbg), 32'd0);
    endtask

    // One sequence: a = abort cycle (-1 none), rd = busy delay after toggle, rl = busy length,
    // extra_en = issue a second start somewhere inside the sequence.
    task automatic applyStimulus(input int seq, input bit dk, input int expm, input int a,
                                 input int rd, input int rl, input bit extra_en);
        int  e;
        int  shut_end;
        int  t;
        int  f;
        int  extra;
        bit  has_read;
        bit  ab;
        e        = (expm == 0) ? 1 : expm * TPM;
        t        = -1;
        f        = 0;
        ab       = 1'b0;
        has_read = 1'b0;
        if (!dk) begin
            if (a >= 1 && a <= S + e) begin
                shut_end = a;
                ab       = 1'b1;
                f        = a + S + 1;
            end else if (a >= S + e + 1 && a <= 2 * S + e) begin
                shut_end = S + e;
                ab       = 1'b1;
                f        = 2 * S + e + 1;
            end else begin
                shut_end = S + e;
                t        = 2 * S + e + 1;
                has_read = 1'b1;
            end
        end else begin
            shut_end = 0;
            if (a >= 1 && a <= e) begin
                ab = 1'b1;
                f  = a + 1;
            end else begin
                t        = e + 1;
                has_read = 1'b1;
            end
        end
        if (has_read) f = t + rd + rl + 1;
        extra = extra_en ? $urandom_range(f, 1) : -1;

        exp_ms = EW'(expm);
        dark   = dk;
        for (int c = 0; c <= f + 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("s%0d_c%0d_shutter", seq, c), 32'(shutter_open),
                        32'(c >= 1 && c <= shut_end));
            checkOutput($sformatf("s%0d_c%0d_toggle", seq, c), 32'(readout_toggle),
                        32'(has_read && c == t));
            checkOutput($sformatf("s%0d_c%0d_busy", seq, c), 32'(busy), 32'(c >= 1 && c <= f));
            checkOutput($sformatf("s%0d_c%0d_done", seq, c), 32'(done), 32'(c == f));
            if (c >= f)
                checkOutput($sformatf("s%0d_c%0d_aborted", seq, c), 32'(aborted), 32'(ab));
            else if (!ab || c <= a)
                checkOutput($sformatf("s%0d_c%0d_aborted", seq, c), 32'(aborted), 32'd0);

            start        = (c == 0) || (c == extra);
            abort        = (c == a);
            readout_busy = has_read && (c >= t + rd) && (c <= t + rd + rl - 1);
            if (c >= 1) begin
                exp_ms = EW'($urandom_range(7, 0));
                dark   = 1'($urandom_range(1, 0));
            end
        end
        start        = 1'b0;
        abort        = 1'b0;
        readout_busy = 1'b0;
    endtask

    // Light frame reset during EXPOSE: every output must be back at reset the next cycle.
    task automatic resetMidExposure(input int seq);
        for (int c = 0; c <= 36; c++) begin
            @(negedge clk);
            if (c == 30)
                checkOutput($sformatf("s%0d_pre_rst_shutter", seq), 32'(shutter_open), 32'd1);
            if (c == 31) begin
                checkOutput($sformatf("s%0d_mid_rst_shutter", seq), 32'(shutter_open), 32'd0);
                checkOutput($sformatf("s%0d_mid_rst_toggle", seq), 32'(readout_toggle), 32'd0);
                checkOutput($sformatf("s%0d_mid_rst_busy", seq), 32'(busy), 32'd0);
                checkOutput($sformatf("s%0d_mid_rst_done", seq), 32'(done), 32'd0);
                checkOutput($sformatf("s%0d_mid_rst_aborted", seq), 32'(aborted), 32'd0);
                checkOutput($sformatf("s%0d_mid_rst_state", seq), 32'(state_dbg), 32'd0);
            end
            if (c > 31) begin
                checkOutput($sformatf("s%0d_c%0d_post_rst_busy", seq, c), 32'(busy), 32'd0);
                checkOutput($sformatf("s%0d_c%0d_post_rst_shutter", seq, c), 32'(shutter_open), 32'd0);
            end
            start  = (c == 0);
            exp_ms = EW'(3);
            dark   = 1'b0;
            rst    = (c == 30);
        end
        rst   = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        exp_ms       = '0;
        dark         = 1'b0;
        readout_busy = 1'b0;
        repeat (2) @(negedge clk);

        resetDut(0); applyStimulus(0, 1'b0, 5, -1, 2, 30, 1'b0);
        resetDut(1); applyStimulus(1, 1'b1, 3, -1, 1, 5, 1'b0);
        resetDut(2); applyStimulus(2, 1'b1, 0, -1, 3, 4, 1'b0);
        resetDut(3); applyStimulus(3, 1'b0, 5, 36, 1, 1, 1'b1);
        resetDut(4); applyStimulus(4, 1'b0, 1, 58, 2, 10, 1'b0);
        resetDut(5); applyStimulus(5, 1'b0, 2, 0, 1, 3, 1'b0);
        resetDut(6); applyStimulus(6, 1'b1, 4, 25, 1, 3, 1'b1);
        resetDut(7); resetMidExposure(7);

        for (int s = 8; s < 32; s++) begin
            int a;
            a = ($urandom_range(1, 0) == 0) ? -1 : int'($urandom_range(2 * S + 80, 0));
            resetDut(s);
            applyStimulus(s, 1'($urandom_range(1, 0)), int'($urandom_range(4, 0)), a,
                          int'($urandom_range(4, 1)), int'($urandom_range(12, 1)),
                          1'($urandom_range(1, 0)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
